// File: rtl/boot_mem_arbiter.sv
// boot_mem_arbiter: 2:1 imem/dmem arbiter onto one memory port, routing responses via an owner FIFO.
// Define BOOT_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise m1 has fixed priority.
module boot_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    s_req_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic                    s_gnt_i,
    input  logic                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    output logic                    protocol_err_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [CW-1:0]              r_count;
    logic [PW-1:0]              r_wptr, r_rptr;
    logic [MAX_OUTSTANDING-1:0] r_fifo;
    logic                       r_lock, r_lock_id, r_last, r_err;
    logic                       w_pick, w_sel_id, w_sel_req, w_push, w_pop, w_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef BOOT_ARB_ROUND_ROBIN_EN
    assign w_pick = ~r_last;
`else
    // last_q is tracked in both builds; it simply cannot change the fixed-priority pick
    assign w_pick = r_last | 1'b1;
`endif

    // A stalled request stays pinned to its owner so address/data hold until the grant
    assign w_sel_id  = r_lock ? r_lock_id : ((m0_req_i & m1_req_i) ? w_pick : m1_req_i);
    assign w_sel_req = w_sel_id ? m1_req_i : m0_req_i;
    assign s_req_o   = w_sel_req & (r_count < CW'(MAX_OUTSTANDING)) & ~rst_i;
    assign s_addr_o  = w_sel_req ? (w_sel_id ? m1_addr_i : m0_addr_i) : '0;
    assign s_we_o    = w_sel_req & (w_sel_id ? m1_we_i : m0_we_i);
    assign s_be_o    = w_sel_req ? (w_sel_id ? m1_be_i : m0_be_i) : '0;
    assign s_wdata_o = w_sel_req ? (w_sel_id ? m1_wdata_i : m0_wdata_i) : '0;

    assign w_push   = s_req_o & s_gnt_i;
    assign m0_gnt_o = w_push & ~w_sel_id;
    assign m1_gnt_o = w_push & w_sel_id;

    assign w_pop       = s_rvalid_i & (r_count != '0);
    assign w_head      = r_fifo[r_rptr];
    assign m0_rvalid_o = w_pop & ~w_head;
    assign m1_rvalid_o = w_pop & w_head;
    assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

    assign protocol_err_o = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_fifo    <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_last    <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_sel_id;
                r_wptr         <= ptr_inc(r_wptr);
                r_last         <= w_sel_id;
            end
            if (w_pop)
                r_rptr <= ptr_inc(r_rptr);
            r_count   <= r_count + CW'(w_push) - CW'(w_pop);
            r_lock    <= s_req_o & ~s_gnt_i;
            r_lock_id <= w_sel_id;
            r_err     <= s_rvalid_i & ~w_pop;
        end
    end
endmodule

// File: tb/tb_boot_mem_arbiter.sv
// tb_boot_mem_arbiter: directed and random stimulus checked against a queue-based reference model.
module tb_boot_mem_arbiter;
    localparam int MAXO = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  req = '0, we = '0;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be [2];
    logic        s_gnt = 1'b0, s_rvalid = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        m0_gnt, m1_gnt, m0_rv, m1_rv, s_req, s_we, perr;
    logic [31:0] m0_rd, m1_rd, s_addr, s_wdata;
    logic [3:0]  s_be;

    int checks = 0, errors = 0;
    int own[$];
    int m_last = 1, m_lock_id = 0;
    bit m_lock = 0, err_exp = 0;
    logic [1:0] seen_gnt, seen_rv;
    logic       seen_sreq;
    logic [31:0] seen_addr;

    always #5 clk = ~clk;

    boot_mem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(req[0]), .m0_gnt_o(m0_gnt), .m0_addr_i(addr[0]), .m0_we_i(we[0]),
        .m0_be_i(be[0]), .m0_wdata_i(wdata[0]), .m0_rvalid_o(m0_rv), .m0_rdata_o(m0_rd),
        .m1_req_i(req[1]), .m1_gnt_o(m1_gnt), .m1_addr_i(addr[1]), .m1_we_i(we[1]),
        .m1_be_i(be[1]), .m1_wdata_i(wdata[1]), .m1_rvalid_o(m1_rv), .m1_rdata_o(m1_rd),
        .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .protocol_err_o(perr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int policy();
`ifdef BOOT_ARB_ROUND_ROBIN_EN
        return (m_last == 0) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    task automatic drive(input bit r0, input bit r1, input bit g, input bit rv);
        req = {r1, r0};
        s_gnt = g;
        s_rvalid = rv;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model at the edge, check the error pulse
    task automatic step();
        int sel, head;
        bit selreq, sreq, pop;
        #4;
        sel    = m_lock ? m_lock_id : ((req[0] && req[1]) ? policy() : (req[1] ? 1 : 0));
        selreq = req[sel];
        sreq   = selreq && own.size() < MAXO;
        pop    = s_rvalid && own.size() > 0;
        head   = pop ? own[0] : 0;
        seen_gnt = {m1_gnt, m0_gnt}; seen_rv = {m1_rv, m0_rv}; seen_sreq = s_req; seen_addr = s_addr;
        chk("s_req", s_req, sreq);
        chk("s_addr", s_addr, selreq ? addr[sel] : 32'h0);
        chk("s_we_be", {s_we, s_be}, selreq ? {we[sel], be[sel]} : 5'h0);
        chk("s_wdata", s_wdata, selreq ? wdata[sel] : 32'h0);
        chk("gnt", {m1_gnt, m0_gnt}, {sreq && s_gnt && sel == 1, sreq && s_gnt && sel == 0});
        chk("rvalid", {m1_rv, m0_rv}, {pop && head == 1, pop && head == 0});
        chk("m0_rdata", m0_rd, (pop && head == 0) ? s_rdata : 32'h0);
        chk("m1_rdata", m1_rd, (pop && head == 1) ? s_rdata : 32'h0);
        @(posedge clk);
        if (pop) void'(own.pop_front());
        if (sreq && s_gnt) begin
            own.push_back(sel);
            m_last = sel;
        end
        m_lock = sreq && !s_gnt;
        m_lock_id = sel;
        err_exp = s_rvalid && !pop;
        #1;
        chk("protocol_err", perr, err_exp);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && own.size() > 0; i++) begin
            drive(0, 0, 0, 1);
            s_rdata = $urandom;
            step();
        end
        drive(0, 0, 0, 0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            addr[i] = 32'h1000 * (i + 1); wdata[i] = $urandom; be[i] = 4'hf;
        end
        #3;
        chk("rst_s_req", s_req, 0);
        chk("rst_gnt", {m1_gnt, m0_gnt}, 0);
        chk("rst_rvalid", {m1_rv, m0_rv}, 0);
        chk("rst_perr", perr, 0);
        @(posedge clk); #1;
        rst = 0;

        // single m0 read
        drive(1, 0, 1, 0); step();
        chk("t1_gnt", seen_gnt, 2'b01);
        drive(0, 0, 0, 1); s_rdata = 32'h200005b7; step();
        chk("t1_rv", seen_rv, 2'b01);
        drive(0, 0, 0, 0); step();

        // continuous contention, responses drain one per cycle
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 1, i > 0); s_rdata = $urandom; step();
`ifdef BOOT_ARB_ROUND_ROBIN_EN
            chk("cont_gnt", seen_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
            chk("cont_gnt", seen_gnt, 2'b10);
`endif
        end
        drain();

        // lock: m0 stalled 3 cycles, m1 joins at cycle 1
        for (int i = 0; i < 4; i++) begin
            drive(1, i > 0, i == 3, 0); step();
            chk("lock_addr", seen_addr, addr[0]);
        end
        chk("lock_m0_gnt", seen_gnt, 2'b01);
        drive(0, 1, 1, 0); step();
        chk("lock_m1_after", seen_gnt, 2'b10);
        drain();

        // full FIFO holds the third request until the cycle after a pop
        drive(1, 0, 1, 0); step();
        drive(0, 1, 1, 0); step();
        drive(1, 0, 1, 0); step();
        chk("full_hold", seen_sreq, 0);
        drive(1, 0, 1, 1); s_rdata = 32'hA0A0A0A0; step();
        chk("full_pop_hold", seen_sreq, 0);
        chk("full_pop_m0", seen_rv, 2'b01);
        drive(1, 0, 1, 0); step();
        chk("full_resume", seen_gnt, 2'b01);
        drive(0, 0, 0, 1); s_rdata = 32'hB1B1B1B1; step();
        chk("order_m1", seen_rv, 2'b10);
        drain();

        // unexpected response
        drive(0, 0, 0, 1); step();
        chk("unexp_perr", perr, 1);
        drive(0, 0, 0, 0); step();
        chk("unexp_perr_once", perr, 0);

        // asynchronous reset with one outstanding transaction
        drive(1, 0, 1, 0); step();
        drive(1, 1, 1, 1);
        #2; rst = 1; #1;
        chk("arst_s_req", s_req, 0);
        chk("arst_gnt", {m1_gnt, m0_gnt}, 0);
        chk("arst_rvalid", {m1_rv, m0_rv}, 0);
        own.delete(); m_last = 1; m_lock = 0; err_exp = 0;
        @(posedge clk); #1;
        chk("arst_perr_held", perr, 0);
        rst = 0;
        drive(0, 0, 0, 1); step();
        chk("arst_drop", seen_rv, 2'b00);
        chk("arst_perr", perr, 1);
        drive(0, 0, 0, 0); step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                addr[i] = $urandom; wdata[i] = $urandom; be[i] = 4'($urandom); we[i] = 1'($urandom);
            end
            s_rdata = $urandom;
            drive(1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
